// File: rtl/main_mem_responder_if.sv
// Request/response handshake bus between an initiator and the main memory responder.
interface main_mem_responder_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic [2:0]               req_memcontrol;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [DATA_WIDTH-1:0]    resp_rdata;
    logic                     resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_memcontrol, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_memcontrol, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/main_mem_responder.sv
// Fixed-latency word-array memory responder with RISC-V byte/half/word loads and stores.
module main_mem_responder #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned INDEX_WIDTH   = 10,
    parameter int unsigned LATENCY       = 4
) (
    input logic                  clk,
    input logic                  rst,
    main_mem_responder_if.slave  bus
);
    localparam int unsigned DEPTH  = 2 ** INDEX_WIDTH;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                   r_state;
    logic [3:0]               r_cnt;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [2:0]               r_mc;
    logic                     r_resp_valid;
    logic                     r_resp_err;
    logic [DATA_WIDTH-1:0]    r_resp_rdata;
    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

    logic [INDEX_WIDTH-1:0]   w_idx;
    logic [1:0]               w_off;
    logic                     w_is_byte;
    logic                     w_is_half;
    logic                     w_misaligned;
    logic                     w_exec;
    logic                     w_wr_en;
    logic [DATA_WIDTH-1:0]    w_word;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [DATA_WIDTH-1:0]    w_load;
    logic [NBYTES-1:0]        w_be;
    logic [DATA_WIDTH-1:0]    w_lanes;
    logic                     w_unused_addr;

    // Upper address bits alias onto the array; they are intentionally dropped.
    assign w_unused_addr = ^r_addr[ADDRESS_WIDTH-1:INDEX_WIDTH+2];

    assign w_idx  = r_addr[INDEX_WIDTH+1:2];
    assign w_off  = r_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_byte = 8'(w_word >> {w_off, 3'b000});
    assign w_half = 16'(w_word >> {w_off[1], 4'b0000});

    // Stores only narrow on 000/001; loads also narrow on the unsigned 100/101 codes.
    assign w_is_byte    = r_we ? (r_mc == 3'b000) : (r_mc[1:0] == 2'b00);
    assign w_is_half    = r_we ? (r_mc == 3'b001) : (r_mc[1:0] == 2'b01);
    assign w_misaligned = w_is_half ? w_off[0] : (!w_is_byte && (w_off != 2'b00));

    assign w_exec  = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_wr_en = w_exec && r_we && !w_misaligned && !rst;

    always_comb begin
        w_load = w_word;
        if (w_is_byte) begin
            w_load = r_mc[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_load = r_mc[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
        end
    end

    always_comb begin
        w_be    = '1;
        w_lanes = r_wdata;
        if (w_is_byte) begin
            w_be    = NBYTES'(1) << w_off;
            w_lanes = {4{r_wdata[7:0]}};
        end else if (w_is_half) begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_lanes = {2{r_wdata[15:0]}};
        end
    end

    // Array has no reset; only byte lanes enabled by the access size are written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_lanes[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_mc    <= bus.req_memcontrol;
                        r_cnt   <= LAT_M1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_misaligned;
                        r_resp_rdata <= (r_we || w_misaligned) ? '0 : w_load;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == IDLE) && !rst;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;

endmodule
